// File: rtl/dcache_ram_arbiter_pkg.sv
// Helpers for walking the round-robin ring of ports 1..n-1; port 0 sits
// outside the ring as the absolute-priority requester.
package dcache_ram_arbiter_pkg;

   // Successor of ring member k in a ring of ports 1..n-1.
   function automatic int unsigned ring_next(input int unsigned k, input int unsigned n);
      return (k >= n - 1) ? 1 : k + 1;
   endfunction

   // Ring member reached by stepping off places from base (base in 1..n-1, off < n-1).
   function automatic int unsigned ring_at(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
      int unsigned idx;
      idx = base + off;
      if (idx > n - 1) idx = idx - (n - 1);
      return idx;
   endfunction

endpackage

// File: rtl/std_cache_pkg.sv
// Shared data-cache geometry and line/byte-enable types used by every cache
// block in the slice. The widths are kept small so the slice elaborates quickly.
package std_cache_pkg;

   localparam int unsigned DCACHE_INDEX_WIDTH = 8;
   localparam int unsigned DCACHE_TAG_WIDTH   = 12;
   localparam int unsigned DCACHE_SET_ASSOC   = 4;
   localparam int unsigned DCACHE_LINE_WIDTH  = 32;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      logic                         dirty;
      logic                         valid;
   } cache_line_t;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]    tag;
      logic [DCACHE_LINE_WIDTH/8-1:0] data;
      logic                           dirty;
      logic                           valid;
   } cl_be_t;

endpackage

// File: rtl/dcache_ram_arbiter_if.sv
// Requester-side and RAM-side bundle of the data-cache RAM arbiter; the
// arbiter uses the slave view, the requesters/RAM model use the master view.
interface dcache_ram_arbiter_if
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS   = 4,
   parameter int unsigned ADDR_WIDTH = DCACHE_INDEX_WIDTH,
   parameter int unsigned SET_ASSOC  = DCACHE_SET_ASSOC
);

   localparam int unsigned ID_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   logic [NR_PORTS-1:0][SET_ASSOC-1:0]        req_i;
   logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]       addr_i;
   logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0] tag_i;
   logic [NR_PORTS-1:0]                       we_i;
   cl_be_t      [NR_PORTS-1:0]                be_i;
   cache_line_t [NR_PORTS-1:0]                wdata_i;
   logic [NR_PORTS-1:0]                       gnt_o;

   logic [SET_ASSOC-1:0]                      req_o;
   logic [ADDR_WIDTH-1:0]                     addr_o;
   logic                                      we_o;
   cl_be_t                                    be_o;
   cache_line_t                               wdata_o;
   cache_line_t [SET_ASSOC-1:0]               rdata_i;

   cache_line_t [SET_ASSOC-1:0]               rdata_o;
   logic [SET_ASSOC-1:0]                      hit_way_o;
   logic [ID_W-1:0]                           rsp_id_o;
   logic                                      rsp_valid_o;

   modport slave (
      input  req_i, addr_i, tag_i, we_i, be_i, wdata_i, rdata_i,
      output gnt_o, req_o, addr_o, we_o, be_o, wdata_o,
      output rdata_o, hit_way_o, rsp_id_o, rsp_valid_o
   );

   modport master (
      output req_i, addr_i, tag_i, we_i, be_i, wdata_i, rdata_i,
      input  gnt_o, req_o, addr_o, we_o, be_o, wdata_o,
      input  rdata_o, hit_way_o, rsp_id_o, rsp_valid_o
   );

endinterface

// File: rtl/dcache_ram_arbiter_rr_starve_arb.sv
// Round-robin arbiter with an absolute-priority port 0 and per-port starvation
// override; reusable in front of any shared cache RAM.
module rr_starve_arb
   import dcache_ram_arbiter_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_WAIT = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lock,
   input  logic [N-1:0] active,
   output logic [N-1:0] gnt
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [PTR_W-1:0]          rr_ptr_q;
   logic [N-1:1][CNT_W-1:0]   wait_cnt_q;
   logic                      starve_hit;
   logic                      rr_hit;
   int unsigned               idx;

   // NOTE: every signal assigned here gets a default before any branch so no latch is inferred.
   always_comb begin
      gnt        = '0;
      starve_hit = 1'b0;
      rr_hit     = 1'b0;
      idx        = 0;
      if (active[0]) begin
         gnt[0] = 1'b1;
      end else if (!lock) begin
         for (int unsigned k = 1; k < N; k++) begin
            if (!starve_hit && active[k] && wait_cnt_q[k] == CNT_W'(MAX_WAIT)) begin
               gnt[k]     = 1'b1;
               starve_hit = 1'b1;
            end
         end
         if (!starve_hit) begin
            for (int unsigned off = 0; off < N - 1; off++) begin
               idx = ring_at(32'(rr_ptr_q), off, N);
               if (!rr_hit && active[idx]) begin
                  gnt[idx] = 1'b1;
                  rr_hit   = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= PTR_W'(1);
         wait_cnt_q <= '0;
      end else begin
         // Lock only suppresses the increment; a dropped request still clears.
         for (int unsigned k = 1; k < N; k++) begin
            if (!active[k] || gnt[k]) begin
               wait_cnt_q[k] <= '0;
            end else if (!lock && wait_cnt_q[k] != CNT_W'(MAX_WAIT)) begin
               wait_cnt_q[k] <= wait_cnt_q[k] + CNT_W'(1);
            end
         end
         for (int unsigned k = 1; k < N; k++) begin
            if (gnt[k]) rr_ptr_q <= PTR_W'(ring_next(k, N));
         end
      end
   end

endmodule

// File: rtl/dcache_ram_arbiter.sv
// Shares the data-cache tag/data RAM between the miss handler (port 0) and the
// PTW/load/store controllers, and computes per-way hits for the granted read.
module dcache_ram_arbiter
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS   = 4,
   parameter int unsigned ADDR_WIDTH = DCACHE_INDEX_WIDTH,
   parameter int unsigned SET_ASSOC  = DCACHE_SET_ASSOC,
   parameter int unsigned MAX_WAIT   = 7
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                lock_i,
   dcache_ram_arbiter_if.slave bus
);

   localparam int unsigned ID_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   logic [NR_PORTS-1:0]         active;
   logic [NR_PORTS-1:0]         gnt;
   logic [ID_W-1:0]             gnt_id;
   logic                        any_gnt;

   logic [ID_W-1:0]             rsp_id_q;
   logic [DCACHE_TAG_WIDTH-1:0] tag_q;
   logic                        rsp_valid_q;

   always_comb begin
      active = '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) active[k] = |bus.req_i[k];
   end

   rr_starve_arb #(
      .N        (NR_PORTS),
      .MAX_WAIT (MAX_WAIT)
   ) u_arb (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .lock   (lock_i),
      .active (active),
      .gnt    (gnt)
   );

   assign bus.gnt_o = gnt;

   // Grant is one-hot-or-zero, so an OR-free priority mux is enough.
   always_comb begin
      bus.req_o   = '0;
      bus.addr_o  = '0;
      bus.we_o    = 1'b0;
      bus.be_o    = '0;
      bus.wdata_o = '0;
      gnt_id      = '0;
      any_gnt     = 1'b0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         if (gnt[k]) begin
            bus.req_o   = bus.req_i[k];
            bus.addr_o  = bus.addr_i[k];
            bus.we_o    = bus.we_i[k];
            bus.be_o    = bus.be_i[k];
            bus.wdata_o = bus.wdata_i[k];
            gnt_id      = ID_W'(k);
            any_gnt     = 1'b1;
         end
      end
   end

   // The RAM answers one cycle after the grant; remember who asked and with which tag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_id_q    <= '0;
         tag_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= any_gnt && !bus.we_i[gnt_id];
         if (any_gnt) begin
            rsp_id_q <= gnt_id;
            tag_q    <= bus.tag_i[gnt_id];
         end
      end
   end

   assign bus.rdata_o     = bus.rdata_i;
   assign bus.rsp_id_o    = rsp_id_q;
   assign bus.rsp_valid_o = rsp_valid_q;

   always_comb begin
      bus.hit_way_o = '0;
      for (int unsigned w = 0; w < SET_ASSOC; w++) begin
         bus.hit_way_o[w] = rsp_valid_q && bus.rdata_i[w].valid && (bus.rdata_i[w].tag == tag_q);
      end
   end

endmodule

// File: tb/tb_dcache_ram_arbiter.sv
// Self-checking bench for dcache_ram_arbiter: a rule-level model of grant
// priority, waiting counters and responses is compared every cycle.
module tb_dcache_ram_arbiter;
   import std_cache_pkg::*;

   localparam int NP = 4;
   localparam int AW = DCACHE_INDEX_WIDTH;
   localparam int SA = DCACHE_SET_ASSOC;
   localparam int MW = 7;
   localparam int TW = DCACHE_TAG_WIDTH;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic lock_i = 1'b0;

   dcache_ram_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .SET_ASSOC(SA)) bus ();

   dcache_ram_arbiter #(
      .NR_PORTS(NP), .ADDR_WIDTH(AW), .SET_ASSOC(SA), .MAX_WAIT(MW)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .lock_i (lock_i),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, in plain integers.
   int          m_rr;
   int          m_wait [NP];
   bit          m_valid;
   int          m_id;
   logic [TW-1:0] m_tag;

   // What the DUT showed in the most recent step.
   logic [NP-1:0] seen_gnt;
   logic [SA-1:0] seen_hit;
   logic          seen_valid;
   logic [1:0]    seen_id;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_pick();
      bit act [NP];
      for (int k = 0; k < NP; k++) act[k] = (bus.req_i[k] != '0);
      if (act[0]) return 0;
      if (lock_i) return -1;
      for (int k = 1; k < NP; k++) if (act[k] && m_wait[k] == MW) return k;
      for (int i = 0; i < NP - 1; i++) begin
         int k;
         k = (m_rr - 1 + i) % (NP - 1) + 1;
         if (act[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_rr    = 1;
      m_valid = 0;
      m_id    = 0;
      m_tag   = '0;
      for (int k = 0; k < NP; k++) m_wait[k] = 0;
   endtask

   task automatic idle_inputs();
      lock_i      = 1'b0;
      bus.req_i   = '0;
      bus.addr_i  = '0;
      bus.tag_i   = '0;
      bus.we_i    = '0;
      bus.be_i    = '0;
      bus.wdata_i = '0;
      bus.rdata_i = '0;
   endtask

   // Called just after a falling edge with inputs set: check, then advance one cycle.
   task automatic step(input string nm);
      int            g;
      logic [NP-1:0] e_gnt;
      logic [SA-1:0] e_hit;
      logic [127:0]  e_mux;
      logic [2:0]    e_rsp;
      int            nx_wait [NP];
      int            nx_rr;
      bit            nx_valid;
      int            nx_id;
      logic [TW-1:0] nx_tag;
      #1;
      g     = model_pick();
      e_gnt = '0;
      e_mux = '0;
      if (g >= 0) begin
         e_gnt[g] = 1'b1;
         e_mux    = {bus.req_i[g], bus.addr_i[g], bus.we_i[g], bus.be_i[g], bus.wdata_i[g]};
      end
      for (int w = 0; w < SA; w++)
         e_hit[w] = m_valid && bus.rdata_i[w].valid && (bus.rdata_i[w].tag == m_tag);
      e_rsp = {m_valid, m_id[1:0]};

      check({nm, ".gnt"}, bus.gnt_o, e_gnt);
      check({nm, ".ram"}, {bus.req_o, bus.addr_o, bus.we_o, bus.be_o, bus.wdata_o}, e_mux);
      check({nm, ".hit"}, bus.hit_way_o, e_hit);
      check({nm, ".rsp"}, {bus.rsp_valid_o, bus.rsp_id_o}, e_rsp);
      check({nm, ".rdata"}, bus.rdata_o, bus.rdata_i);
      seen_gnt   = bus.gnt_o;
      seen_hit   = bus.hit_way_o;
      seen_valid = bus.rsp_valid_o;
      seen_id    = bus.rsp_id_o;

      nx_wait = m_wait;
      nx_rr   = m_rr;
      for (int k = 1; k < NP; k++) begin
         if (bus.req_i[k] == '0 || g == k) nx_wait[k] = 0;
         else if (!lock_i && m_wait[k] < MW) nx_wait[k] = m_wait[k] + 1;
      end
      if (g >= 1) nx_rr = (g == NP - 1) ? 1 : g + 1;
      nx_valid = 0;
      nx_id    = m_id;
      nx_tag   = m_tag;
      if (g >= 0) begin
         nx_valid = !bus.we_i[g];
         nx_id    = g;
         nx_tag   = bus.tag_i[g];
      end
      @(posedge clk_i);
      if (rst_ni) begin
         m_wait  = nx_wait;
         m_rr    = nx_rr;
         m_valid = nx_valid;
         m_id    = nx_id;
         m_tag   = nx_tag;
      end
      @(negedge clk_i);
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      #1;
      model_reset();
      check("reset.rsp_valid", bus.rsp_valid_o, 1'b0);
      check("reset.hit", bus.hit_way_o, '0);
      check("reset.rsp_id", bus.rsp_id_o, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic rand_inputs();
      logic [63:0] r;
      if (lock_i) lock_i = ($urandom_range(0, 3) != 0);
      else        lock_i = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NP; k++) begin
         bit on;
         on = (k == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 6);
         bus.req_i[k]  = on ? SA'($urandom_range(1, (1 << SA) - 1)) : '0;
         bus.addr_i[k] = AW'($urandom);
         bus.tag_i[k]  = ($urandom_range(0, 1) != 0) ? TW'(12'h1A5) : TW'($urandom);
         bus.we_i[k]   = ($urandom_range(0, 9) < 3);
         r = {$urandom(), $urandom()};
         bus.be_i[k]    = r[$bits(cl_be_t)-1:0];
         r = {$urandom(), $urandom()};
         bus.wdata_i[k] = r[$bits(cache_line_t)-1:0];
      end
      for (int w = 0; w < SA; w++) begin
         r = {$urandom(), $urandom()};
         bus.rdata_i[w]       = r[$bits(cache_line_t)-1:0];
         bus.rdata_i[w].valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) != 0) bus.rdata_i[w].tag = m_tag;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      model_reset();
      @(negedge clk_i);
      apply_reset();

      // Idle: no grant, muxed RAM controls all zero.
      step("idle");
      check("idle.gnt_lit", seen_gnt, 4'b0000);

      // Ports 1..3 active from rr_ptr=1: strict rotation.
      bus.req_i[1] = 4'b0001; bus.req_i[2] = 4'b0010; bus.req_i[3] = 4'b1000;
      bus.we_i = '1;
      for (int i = 0; i < 6; i++) begin
         logic [NP-1:0] lit;
         step("rr");
         lit = '0;
         lit[1 + (i % 3)] = 1'b1;
         check("rr.order_lit", seen_gnt, lit);
      end

      // Read hit: port 1, tag 0x1A5, only way 2 valid with that tag.
      idle_inputs(); apply_reset();
      bus.req_i[1] = 4'b0100; bus.tag_i[1] = 12'h1A5; bus.addr_i[1] = 8'h3C;
      step("hit.req");
      check("hit.gnt_lit", seen_gnt, 4'b0010);
      bus.req_i = '0;
      bus.rdata_i[0].tag = 12'h1A5; bus.rdata_i[0].valid = 1'b0;
      bus.rdata_i[1].tag = 12'h000; bus.rdata_i[1].valid = 1'b1;
      bus.rdata_i[2].tag = 12'h1A5; bus.rdata_i[2].valid = 1'b1;
      bus.rdata_i[3].tag = 12'h1A4; bus.rdata_i[3].valid = 1'b1;
      step("hit.rsp");
      check("hit.way_lit", seen_hit, 4'b0100);
      check("hit.rsp_lit", {seen_valid, seen_id}, 3'b101);

      // Port 0 absolute: port 2 never wins, its counter saturates and then forces a grant.
      idle_inputs(); apply_reset();
      bus.req_i[0] = 4'b0001; bus.req_i[2] = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         step("p0abs");
         check("p0abs.gnt_lit", seen_gnt, 4'b0001);
      end
      bus.req_i[0] = '0; bus.req_i[1] = 4'b0001; bus.req_i[3] = 4'b0001;
      step("p0abs.starve");
      check("p0abs.starve_lit", seen_gnt, 4'b0100);

      // Port 3 starves for 7 cycles, then beats the round-robin choice.
      idle_inputs(); apply_reset();
      bus.req_i[0] = 4'b0001; bus.req_i[3] = 4'b0001;
      for (int i = 0; i < 6; i++) step("starve.build");
      bus.req_i[0] = '0; bus.req_i[1] = 4'b0001;
      step("starve.c7");
      check("starve.c7_lit", seen_gnt, 4'b0010);
      bus.req_i[2] = 4'b0001;
      step("starve.c8");
      check("starve.c8_lit", seen_gnt, 4'b1000);

      // Lock: only port 0; frozen counters mean port 3 wins by round-robin afterwards.
      idle_inputs(); apply_reset();
      bus.req_i[1] = 4'b0001;
      step("lock.pre");
      lock_i = 1'b1; bus.req_i[0] = 4'b0001; bus.req_i[3] = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         step("lock.on");
         check("lock.gnt_lit", seen_gnt, 4'b0001);
      end
      bus.req_i[0] = '0;
      step("lock.hold");
      check("lock.none_lit", seen_gnt, 4'b0000);
      lock_i = 1'b0;
      step("lock.off");
      check("lock.rr_lit", seen_gnt, 4'b1000);
      bus.req_i[3] = '0;
      step("lock.p1");
      check("lock.p1_lit", seen_gnt, 4'b0010);

      // Reset one cycle after a port 2 read grant drops the pending response.
      idle_inputs(); apply_reset();
      bus.req_i[2] = 4'b0001; bus.tag_i[2] = 12'h0F0;
      step("rst.grant");
      bus.req_i = '0;
      bus.rdata_i[1].tag = 12'h0F0; bus.rdata_i[1].valid = 1'b1;
      #1;
      check("rst.pending", bus.rsp_valid_o, 1'b1);
      apply_reset();
      bus.req_i[1] = 4'b0001; bus.req_i[2] = 4'b0001; bus.req_i[3] = 4'b0001;
      step("rst.after");
      check("rst.rr_lit", seen_gnt, 4'b0010);

      // Randomized traffic with occasional mid-run resets.
      idle_inputs(); apply_reset();
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         if ($urandom_range(0, 499) == 0) apply_reset();
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
